// File: rtl/usb_tx_scheduler_pkg.sv
// Shared USB transmit definitions: scheduler state encodings, handshake and data PID type codes.
package usb_tx_scheduler_pkg;

   typedef enum logic [5:0] {
      ST_IDLE    = 6'b000001,
      ST_HSK     = 6'b000010,
      ST_HSK_END = 6'b000100,
      ST_START   = 6'b001000,
      ST_DATA    = 6'b010000,
      ST_DONE    = 6'b100000
   } state_e;

   localparam logic [1:0] HSK_ACK   = 2'b00;
   localparam logic [1:0] HSK_NAK   = 2'b10;
   localparam logic [1:0] HSK_STALL = 2'b11;

   localparam logic [1:0] TYPE_DATA0 = 2'b00;
   localparam logic [1:0] TYPE_DATA1 = 2'b10;

   function automatic logic [1:0] data_type(input logic tog);
      return tog ? TYPE_DATA1 : TYPE_DATA0;
   endfunction

endpackage

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshakes and two IN endpoints onto one packet encoder; grant one cycle after request, data
// passes combinationally from the granted endpoint, so encoder backpressure reaches it in the same cycle.
module usb_tx_scheduler
   import usb_tx_scheduler_pkg::*;
#(
   parameter bit EP1_PRIO = 1'b0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       hsk_req_i,
   input  logic [1:0] hsk_type_i,
   output logic       hsk_ack_o,
   input  logic       ep0_req_i,
   input  logic       ep0_tvalid_i,
   input  logic       ep0_tlast_i,
   input  logic [7:0] ep0_tdata_i,
   output logic       ep0_tready_o,
   output logic       ep0_done_o,
   input  logic       ep1_req_i,
   input  logic       ep1_tvalid_i,
   input  logic       ep1_tlast_i,
   input  logic [7:0] ep1_tdata_i,
   output logic       ep1_tready_o,
   output logic       ep1_done_o,
   input  logic [1:0] tog_clr_i,
   input  logic [1:0] tog_adv_i,
   output logic       enc_hsk_send_o,
   output logic [1:0] enc_hsk_type_o,
   input  logic       enc_hsk_done_i,
   output logic       enc_trn_start_o,
   output logic [1:0] enc_trn_type_o,
   output logic       enc_tvalid_o,
   output logic       enc_tlast_o,
   output logic [7:0] enc_tdata_o,
   input  logic       enc_tready_i,
   input  logic       phy_tvalid_i,
   input  logic       phy_tready_i,
   input  logic       phy_tlast_i,
   output logic       busy_o,
   output logic [1:0] grant_o
);

   state_e     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] tog_q, tog_d;
   logic [1:0] hsk_type_q, hsk_type_d;
   logic [1:0] trn_type_q, trn_type_d;
   logic       ep1_wins;
   logic       phy_last;

   assign ep1_wins = ep1_req_i & (EP1_PRIO | ~ep0_req_i);
   assign phy_last = phy_tvalid_i & phy_tready_i & phy_tlast_i;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= 2'b00;
         tog_q      <= 2'b00;
         hsk_type_q <= HSK_ACK;
         trn_type_q <= TYPE_DATA0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         tog_q      <= tog_d;
         hsk_type_q <= hsk_type_d;
         trn_type_q <= trn_type_d;
      end
   end

   // Clear has priority so a host reset of the sequence cannot be undone by a coincident ACK.
   always_comb begin
      tog_d = tog_q;
      for (int n = 0; n < 2; n++) begin
         if (tog_clr_i[n]) begin
            tog_d[n] = 1'b0;
         end else if (tog_adv_i[n]) begin
            tog_d[n] = ~tog_q[n];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      hsk_type_d = hsk_type_q;
      trn_type_d = trn_type_q;
      unique case (state_q)
         ST_IDLE: begin
            if (hsk_req_i) begin
               state_d    = ST_HSK;
               hsk_type_d = hsk_type_i;
            end else if (ep0_req_i || ep1_req_i) begin
               state_d    = ST_START;
               grant_d    = ep1_wins ? 2'b10 : 2'b01;
               trn_type_d = data_type(ep1_wins ? tog_q[1] : tog_q[0]);
            end
         end
         ST_HSK: begin
            if (enc_hsk_done_i) begin
               state_d = ST_HSK_END;
            end
         end
         ST_HSK_END: begin
            if (!enc_hsk_done_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (phy_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      hsk_ack_o       = 1'b0;
      enc_hsk_send_o  = 1'b0;
      enc_trn_start_o = 1'b0;
      enc_tvalid_o    = 1'b0;
      enc_tlast_o     = 1'b0;
      enc_tdata_o     = 8'h00;
      ep0_tready_o    = 1'b0;
      ep1_tready_o    = 1'b0;
      ep0_done_o      = 1'b0;
      ep1_done_o      = 1'b0;
      unique case (state_q)
         ST_HSK: begin
            enc_hsk_send_o = 1'b1;
            hsk_ack_o      = enc_hsk_done_i;
         end
         ST_HSK_END: begin
            enc_hsk_send_o = 1'b1;
         end
         ST_START, ST_DATA: begin
            enc_trn_start_o = (state_q == ST_START);
            enc_tvalid_o    = grant_q[1] ? ep1_tvalid_i : ep0_tvalid_i;
            enc_tlast_o     = grant_q[1] ? ep1_tlast_i  : ep0_tlast_i;
            enc_tdata_o     = grant_q[1] ? ep1_tdata_i  : ep0_tdata_i;
            ep0_tready_o    = grant_q[0] & enc_tready_i;
            ep1_tready_o    = grant_q[1] & enc_tready_i;
         end
         ST_DONE: begin
            ep0_done_o = grant_q[0];
            ep1_done_o = grant_q[1];
         end
         default: begin
         end
      endcase
   end

   assign busy_o         = (state_q != ST_IDLE);
   assign grant_o        = grant_q;
   assign enc_hsk_type_o = hsk_type_q;
   assign enc_trn_type_o = trn_type_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler with behavioural endpoints and a minimal packet encoder.
module tb_usb_tx_scheduler;

   logic       clock, reset_n;
   logic       hsk_req_i, hsk_ack_o;
   logic [1:0] hsk_type_i;
   logic       ep0_req_i, ep0_tvalid_i, ep0_tlast_i, ep0_tready_o, ep0_done_o;
   logic       ep1_req_i, ep1_tvalid_i, ep1_tlast_i, ep1_tready_o, ep1_done_o;
   logic [7:0] ep0_tdata_i, ep1_tdata_i;
   logic [1:0] tog_clr_i, tog_adv_i;
   logic       enc_hsk_send_o, enc_hsk_done_i, enc_trn_start_o;
   logic [1:0] enc_hsk_type_o, enc_trn_type_o, grant_o;
   logic       enc_tvalid_o, enc_tlast_o, enc_tready_i, busy_o;
   logic [7:0] enc_tdata_o;
   logic       phy_tvalid_i, phy_tready_i, phy_tlast_i;

   usb_tx_scheduler #(.EP1_PRIO(1'b0)) dut (
      .clock(clock), .reset_n(reset_n),
      .hsk_req_i(hsk_req_i), .hsk_type_i(hsk_type_i), .hsk_ack_o(hsk_ack_o),
      .ep0_req_i(ep0_req_i), .ep0_tvalid_i(ep0_tvalid_i), .ep0_tlast_i(ep0_tlast_i),
      .ep0_tdata_i(ep0_tdata_i), .ep0_tready_o(ep0_tready_o), .ep0_done_o(ep0_done_o),
      .ep1_req_i(ep1_req_i), .ep1_tvalid_i(ep1_tvalid_i), .ep1_tlast_i(ep1_tlast_i),
      .ep1_tdata_i(ep1_tdata_i), .ep1_tready_o(ep1_tready_o), .ep1_done_o(ep1_done_o),
      .tog_clr_i(tog_clr_i), .tog_adv_i(tog_adv_i),
      .enc_hsk_send_o(enc_hsk_send_o), .enc_hsk_type_o(enc_hsk_type_o), .enc_hsk_done_i(enc_hsk_done_i),
      .enc_trn_start_o(enc_trn_start_o), .enc_trn_type_o(enc_trn_type_o),
      .enc_tvalid_o(enc_tvalid_o), .enc_tlast_o(enc_tlast_o), .enc_tdata_o(enc_tdata_o),
      .enc_tready_i(enc_tready_i),
      .phy_tvalid_i(phy_tvalid_i), .phy_tready_i(phy_tready_i), .phy_tlast_i(phy_tlast_i),
      .busy_o(busy_o), .grant_o(grant_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   wire [23:0] all_outs = {hsk_ack_o, ep0_tready_o, ep1_tready_o, ep0_done_o, ep1_done_o,
                           enc_hsk_send_o, enc_hsk_type_o, enc_trn_start_o, enc_trn_type_o,
                           enc_tvalid_o, enc_tlast_o, enc_tdata_o, busy_o, grant_o};

   // Endpoint sources: e_len bytes of e_base+index; length 0 presents a ZLP.
   logic [7:0] e_len [2];
   logic [7:0] e_base[2];
   logic [7:0] e_idx [2];

   assign ep0_tvalid_i = e_idx[0] < e_len[0];
   assign ep1_tvalid_i = e_idx[1] < e_len[1];
   assign ep0_tlast_i  = (e_len[0] == 8'd0) || (e_idx[0] + 8'd1 == e_len[0]);
   assign ep1_tlast_i  = (e_len[1] == 8'd0) || (e_idx[1] + 8'd1 == e_len[1]);
   assign ep0_tdata_i  = e_base[0] + e_idx[0];
   assign ep1_tdata_i  = e_base[1] + e_idx[1];

   always @(posedge clock) begin
      if (!reset_n) begin
         e_idx[0] <= 8'd0;
         e_idx[1] <= 8'd0;
      end else begin
         if (ep0_tvalid_i && ep0_tready_o) e_idx[0] <= e_idx[0] + 8'd1;
         if (ep1_tvalid_i && ep1_tready_o) e_idx[1] <= e_idx[1] + 8'd1;
         if (ep0_done_o) e_idx[0] <= 8'd0;
         if (ep1_done_o) e_idx[1] <= 8'd0;
      end
   end

   // Encoder model: phase 1 forwards payload, phase 2 emits two CRC bytes, last on the second.
   logic [1:0] phase;
   logic       crc_i;
   logic [1:0] hcnt;

   assign enc_tready_i   = (phase == 2'd1);
   assign phy_tvalid_i   = (phase == 2'd2) || ((phase == 2'd1) && enc_tvalid_o);
   assign phy_tready_i   = phy_tvalid_i;
   assign phy_tlast_i    = (phase == 2'd2) && crc_i;
   assign enc_hsk_done_i = enc_hsk_send_o && (hcnt == 2'd2);

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase <= 2'd0;
         crc_i <= 1'b0;
         hcnt  <= 2'd0;
      end else begin
         if (!enc_hsk_send_o) hcnt <= 2'd0;
         else if (hcnt != 2'd3) hcnt <= hcnt + 2'd1;
         case (phase)
            2'd0: if (enc_trn_start_o) phase <= 2'd1;
            2'd1: begin
               if (enc_tlast_o && (!enc_tvalid_o || enc_tready_i)) begin
                  phase <= 2'd2;
                  crc_i <= 1'b0;
               end
            end
            2'd2: begin
               crc_i <= 1'b1;
               if (crc_i) phase <= 2'd0;
            end
            default: phase <= 2'd0;
         endcase
      end
   end

   function automatic logic [7:0] pid_of(input logic [1:0] t);
      case (t)
         2'b00:   return 8'hD2;
         2'b10:   return 8'h5A;
         2'b11:   return 8'h1E;
         default: return 8'h00;
      endcase
   endfunction

   typedef struct packed {
      logic [1:0]  grant;
      logic [1:0]  typ;
      logic [7:0]  len;
      logic [15:0] sum;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] hsq[$];
   int         m_cnt = 0;
   logic [15:0] m_sum = 16'd0;
   logic       prev_done = 1'b0;

   always @(negedge clock) begin
      exp_t e;
      logic done;
      if (reset_n) begin
         if (enc_trn_start_o) begin
            m_cnt = 0;
            m_sum = 16'd0;
         end
         if (enc_tvalid_o && enc_tready_i) begin
            m_cnt++;
            m_sum = m_sum + {8'h00, enc_tdata_o};
         end
         done = ep0_done_o | ep1_done_o;
         if (done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("grant", {30'd0, grant_o}, {30'd0, e.grant});
               chk("done_ep", {30'd0, ep1_done_o, ep0_done_o}, {30'd0, e.grant});
               chk("data_type", {30'd0, enc_trn_type_o}, {30'd0, e.typ});
               chk("byte_count", m_cnt, {24'd0, e.len});
               chk("byte_sum", {16'd0, m_sum}, {16'd0, e.sum});
            end
            if (prev_done) chk("done_width", 2, 1);
         end
         prev_done = done;
         if (hsk_ack_o) begin
            if (hsq.size() == 0) chk("unexpected_ack", 1, 0);
            else chk("hsk_pid", {24'd0, pid_of(enc_hsk_type_o)}, {24'd0, hsq.pop_front()});
         end
      end else begin
         prev_done = 1'b0;
      end
   end

   logic [1:0] tog_m;

   task automatic wait_for(input int which);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clock);
         case (which)
            0:       ok = ep0_done_o;
            1:       ok = ep1_done_o;
            2:       ok = hsk_ack_o;
            3:       ok = !busy_o;
            4:       ok = enc_trn_start_o;
            default: ok = (m_cnt >= 2);
         endcase
      end
      if (!ok) chk($sformatf("timeout_%0d", which), 0, 1);
   endtask

   task automatic expect_pkt(input int ep, input logic [7:0] len, input logic [7:0] base);
      exp_t e;
      logic [7:0] b;
      e.grant = (ep == 1) ? 2'b10 : 2'b01;
      e.typ   = {tog_m[ep], 1'b0};
      e.len   = len;
      e.sum   = 16'd0;
      for (int i = 0; i < int'(len); i++) begin
         b = base + 8'(i);
         e.sum = e.sum + {8'h00, b};
      end
      e_len[ep]  = len;
      e_base[ep] = base;
      sbq.push_back(e);
   endtask

   task automatic send_pkt(input int ep, input logic [7:0] len, input logic [7:0] base);
      expect_pkt(ep, len, base);
      if (ep == 1) ep1_req_i = 1'b1; else ep0_req_i = 1'b1;
      wait_for(ep);
      ep0_req_i = 1'b0;
      ep1_req_i = 1'b0;
      wait_for(3);
   endtask

   task automatic tog_pulse(input logic [1:0] clr, input logic [1:0] adv);
      tog_clr_i = clr;
      tog_adv_i = adv;
      for (int n = 0; n < 2; n++) begin
         if (clr[n]) tog_m[n] = 1'b0;
         else if (adv[n]) tog_m[n] = ~tog_m[n];
      end
      @(negedge clock);
      tog_clr_i = 2'b00;
      tog_adv_i = 2'b00;
   endtask

   task automatic do_hsk(input logic [1:0] t, input logic [7:0] pid_exp);
      hsq.push_back(pid_exp);
      hsk_type_i = t;
      hsk_req_i  = 1'b1;
      @(negedge clock);
      chk("hsk_send", {31'd0, enc_hsk_send_o}, 1);
      chk("hsk_grant", {30'd0, grant_o}, 0);
      wait_for(2);
      hsk_req_i = 1'b0;
      wait_for(3);
      chk("hsk_send_off", {31'd0, enc_hsk_send_o}, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      hsk_req_i = 1'b0; hsk_type_i = 2'b00;
      ep0_req_i = 1'b0; ep1_req_i = 1'b0;
      tog_clr_i = 2'b00; tog_adv_i = 2'b00;
      e_len[0] = 8'd0; e_len[1] = 8'd0; e_base[0] = 8'd0; e_base[1] = 8'd0;
      tog_m = 2'b00;
      repeat (3) @(negedge clock);
      chk("reset_outs", {8'd0, all_outs}, 0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle_outs", {8'd0, all_outs}, 0);

      do_hsk(2'b10, 8'h5A);
      do_hsk(2'b00, 8'hD2);
      do_hsk(2'b11, 8'h1E);

      // Simultaneous requests: EP0 wins, EP1 follows.
      expect_pkt(0, 8'd4, 8'h10);
      expect_pkt(1, 8'd2, 8'h20);
      ep0_req_i = 1'b1;
      ep1_req_i = 1'b1;
      wait_for(0);
      ep0_req_i = 1'b0;
      wait_for(1);
      ep1_req_i = 1'b0;
      wait_for(3);

      for (int k = 0; k < 3; k++) begin
         send_pkt(1, 8'd3, 8'h30 + 8'(k * 16));
         tog_pulse(2'b00, 2'b10);
      end

      send_pkt(0, 8'd0, 8'h00);

      tog_pulse(2'b00, 2'b01);
      tog_pulse(2'b01, 2'b01);
      send_pkt(0, 8'd2, 8'h40);

      // Toggle flip mid-packet must not disturb the latched type.
      expect_pkt(0, 8'd6, 8'h50);
      ep0_req_i = 1'b1;
      wait_for(4);
      tog_pulse(2'b00, 2'b01);
      wait_for(0);
      ep0_req_i = 1'b0;
      wait_for(3);
      send_pkt(0, 8'd1, 8'h60);

      // Handshake raised during a data packet waits for it to finish.
      expect_pkt(1, 8'd5, 8'h70);
      hsq.push_back(8'h1E);
      ep1_req_i = 1'b1;
      wait_for(4);
      hsk_type_i = 2'b11;
      hsk_req_i  = 1'b1;
      wait_for(1);
      chk("hsk_waits", hsq.size(), 1);
      ep1_req_i = 1'b0;
      wait_for(2);
      hsk_req_i = 1'b0;
      wait_for(3);

      // Reset mid-packet with tog[0]=1.
      chk("tog0_set_before_reset", {31'd0, tog_m[0]}, 1);
      e_len[0] = 8'd8;
      e_base[0] = 8'h80;
      ep0_req_i = 1'b1;
      wait_for(4);
      wait_for(5);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_outs", {8'd0, all_outs}, 0);
      ep0_req_i = 1'b0;
      tog_m = 2'b00;
      repeat (2) @(negedge clock);
      chk("rst_held_outs", {8'd0, all_outs}, 0);
      reset_n = 1'b1;
      @(negedge clock);
      send_pkt(0, 8'd2, 8'h90);

      chk("sb_drained", sbq.size() + hsq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
